// File: rtl/mem_xfer_master.sv
// Multi-word load/store sequencer for the 64x16 memory port.
// Walks an 8-bit register mask lowest-index first. For each set bit it issues one
// active-low read or write strobe at consecutive memory addresses and moves the word
// between the memory and the register file.
module mem_xfer_master #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_mask,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_n,
  output logic              mem_read_n,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StDone} state_e;

  state_e              state_q;
  logic                op_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [NREG-1:0]     rem_mask_q;
  logic [IDX_W-1:0]    idx;
  logic [NREG-1:0]     rem_mask_clr;

  // Priority encoder: lowest set bit of the remaining mask wins.
  always_comb begin
    idx = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (rem_mask_q[i]) idx = IDX_W'(i);
    end
    rem_mask_clr = rem_mask_q & ~(NREG'(1) << idx);
  end

  assign rf_raddr = idx;
  assign busy     = (state_q != StIdle);

  // Sequencer FSM; every memory-side and RF-side output is registered here.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      cur_addr_q  <= '0;
      rem_mask_q  <= '0;
      done        <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write_n <= 1'b1;
      mem_read_n  <= 1'b1;
    end else begin
      done  <= 1'b0;
      rf_we <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q       <= op;
            cur_addr_q <= base_addr;
            rem_mask_q <= reg_mask;
            if (reg_mask != '0) begin
              state_q <= StSetup;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StSetup: begin
          mem_addr <= cur_addr_q;
          if (op_q) begin
            mem_wdata   <= rf_rdata;
            mem_write_n <= 1'b0;
          end else begin
            mem_read_n <= 1'b0;
          end
          state_q <= StStrobe;
        end
        StStrobe: begin
          // Memory acted on the negedge inside this cycle; release the strobe now.
          mem_write_n <= 1'b1;
          mem_read_n  <= 1'b1;
          rem_mask_q  <= rem_mask_clr;
          cur_addr_q  <= cur_addr_q + ADDR_W'(1);
          if (!op_q) begin
            rf_we    <= 1'b1;
            rf_waddr <= idx;
            rf_wdata <= mem_rdata;
          end
          if (rem_mask_clr != '0) begin
            state_q <= StSetup;
          end else begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_xfer_master.md
Name: mem_xfer_master

Overview:
- Initiator side of the 64x16 word memory port: a multi-word load/store sequencer for LM/SM-class instructions.
- Takes a base address and an 8-bit register mask from the control path.
- For each set bit, it issues one active-low read or write strobe to the memory and moves data between the memory and the register file.
- Sits between the controller FSM, the register file and the memory.

Parameters:
- ADDR_W, 6, memory word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, data word width.
- NREG, 8, register count, equal to the mask width.
- IDX_W, 3, register index width, log2(NREG).

Ports:
- clk  in  1  clock; all state changes on posedge.
- proc_rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  1  0 = load (mem->RF), 1 = store (RF->mem).
- base_addr  in  ADDR_W  first memory address.
- reg_mask  in  NREG  bit i set means transfer register i.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- rf_raddr  out  IDX_W  RF read index (store data source).
- rf_rdata  in  DATA_W  RF read data, combinational from rf_raddr.
- rf_we  out  1  RF write enable pulse (load).
- rf_waddr  out  IDX_W  RF write index.
- rf_wdata  out  DATA_W  RF write data.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_write_n  out  1  active-low write strobe (registered).
- mem_read_n  out  1  active-low read strobe (registered).
- mem_rdata  in  DATA_W  memory read data; updated by the memory on negedge while mem_read_n = 0.

Behaviour:
- Reset values (applied at the first posedge with proc_rst = 1, overriding everything else):
  - state IDLE, busy 0, done 0, rf_we 0, mem_write_n 1, mem_read_n 1.
  - mem_addr 0, mem_wdata 0, rf_waddr 0, rf_wdata 0.
  - Internal mask, index and address registers cleared.
- Reset mid-operation: the transfer is aborted. No further strobe, rf_we or done is produced.
- States: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - If start = 1, latch op, base_addr (into cur_addr) and reg_mask (into rem_mask).
  - Next state is SETUP if reg_mask != 0, else DONE.
  - start is ignored in all other states, and the latched command is not disturbed.
- SETUP:
  - idx = lowest set bit of rem_mask (priority encoder); rf_raddr = idx (combinational).
  - At the edge: mem_addr <= cur_addr.
  - Store: mem_wdata <= rf_rdata and mem_write_n <= 0.
  - Load: mem_read_n <= 0.
  - Next state: STROBE.
- STROBE:
  - The strobe is low for exactly this one cycle; the memory acts on the intervening negedge.
  - At the edge: strobes <= 1, rem_mask[idx] <= 0, cur_addr <= cur_addr + 1 (mod 2^ADDR_W).
  - Load: rf_we <= 1, rf_waddr <= idx, rf_wdata <= mem_rdata.
  - Next state: SETUP if the cleared rem_mask != 0, else DONE.
- DONE: done = 1 for this cycle; next state IDLE.
- rf_we is a registered one-cycle pulse; it is never high on a store.
- The final load's rf_we coincides with done.
- Timing: start sampled at edge e0 with k set bits gives:
  - SETUP/STROBE pairs in cycles 1..2k;
  - strobes low in cycles 2, 4, ..., 2k;
  - done in cycle 2k+1;
  - IDLE in cycle 2k+2.
- Empty mask: done in cycle 1, no strobes, busy high for 1 cycle.
- Register order is ascending index, and memory addresses are consecutive regardless of gaps in the mask. Example: mask 0x81 maps R0 to base and R7 to base+1.
- mem_read_n and mem_write_n are never low simultaneously.
- mem_addr and mem_wdata hold their value after the strobe until the next SETUP.

Test Plan:
- Store, base 10, mask 0x05, R0 = 0x1111, R2 = 0x2222 -> mem_write_n low in cycles 2 and 4 at addresses 10 and 11; mem[10] = 0x1111, mem[11] = 0x2222; done in cycle 5; mem_read_n stays 1.
- Load, base 5, mask 0x80, mem[5] = 0xBEEF -> mem_read_n low in cycle 2 at addr 5; rf_we = 1 in cycle 3 with waddr 7 and wdata 0xBEEF, coincident with done.
- Empty mask, either op -> done in cycle 1, busy high only in cycle 1, no strobe, no rf_we.
- Load, base 62, mask 0x0F, mem[62, 63, 0, 1] = 0xA0..0xA3 -> addresses 62, 63, 0, 1 in order; R0..R3 = 0xA0..0xA3; done in cycle 9.
- Load, mask 0xFF, base 0 -> 8 read strobes and 8 rf_we pulses with idx 0..7; done in cycle 17; a second start asserted in cycle 4 is ignored.
- Store, mask 0x03, proc_rst = 1 during the first STROBE -> at the next edge strobes = 1, busy = 0, done never asserts; the mem[base+1] write never occurs.
